// File: rtl/zb_decoder_pkg.sv
// ============================================================================
// Module   : zb_decoder_pkg
// Brief    : Shared types for the decoder sequencer (sample format, FSM states).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package zb_decoder_pkg;

    localparam int IQ_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [IQ_W-1:0] i;
        logic [IQ_W-1:0] q;
    } iq_sample_t;

endpackage

`default_nettype wire

// File: rtl/zb_iq_fifo.sv
// ============================================================================
// Module   : zb_iq_fifo
// Brief    : Small synchronous FIFO of I/Q samples with flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module zb_iq_fifo
    import zb_decoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [2*IQ_W-1:0]     i_wr_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [2*IQ_W-1:0]     o_rd_data,
    output logic                  full,
    output logic                  empty
);

    localparam int c_AW = $clog2(DEPTH);

    iq_sample_t       r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (c_AW+1)'(DEPTH));
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign o_rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

`default_nettype wire

// File: rtl/zb_decoder_sequencer.sv
// ============================================================================
// Module   : zb_decoder_sequencer
// Brief    : Buffers ADC I/Q samples and replays them to the decoder with an
//            eoc strobe every EOC_PERIOD cycles; warm-up/lock FSM.
//            Optional watchdog: define ZB_SEQ_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module zb_decoder_sequencer
    import zb_decoder_pkg::*;
#(
    parameter int EOC_PERIOD     = 5,
    parameter int FIFO_DEPTH     = 4,
    parameter int WARMUP_SAMPLES = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       adc_valid,
    input  logic [3:0] adc_i,
    input  logic [3:0] adc_q,
    input  logic       postfilter_ready,
    output logic       eoc,
    output logic [3:0] i_if,
    output logic [3:0] q_if,
    output logic [1:0] state,
    output logic       locked,
    output logic       overflow,
    output logic       underflow,
    output logic       timeout
);

    localparam logic [7:0] c_PERIOD_LAST = 8'(EOC_PERIOD - 1);
    localparam logic [7:0] c_WARM_N      = 8'(WARMUP_SAMPLES);

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;
    logic [7:0]          r_period;
    logic [7:0]          r_warm_cnt;
    logic                r_eoc;
    logic [3:0]          r_i_if;
    logic [3:0]          r_q_if;
    logic                r_locked;
    logic                r_overflow;
    logic                r_underflow;
    logic                r_timeout;
    logic                w_active;
    logic                w_strobe;
    logic                w_push;
    logic                w_full;
    logic                w_empty;
    logic                w_warm_done;
    logic                w_wd_expire;
    logic [2*IQ_W-1:0]   w_head_bits;
    iq_sample_t          w_head;

    assign w_active    = (r_state != IDLE);
    assign w_strobe    = w_active && (r_period == c_PERIOD_LAST);
    assign w_push      = w_active && adc_valid;
    assign w_warm_done = (r_state == WARMUP) && (r_warm_cnt == c_WARM_N);
    assign w_head      = w_head_bits;

    zb_iq_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .i_wr_data ({adc_i, adc_q}),
        .pop       (w_strobe),
        .flush     (!w_active),
        .o_rd_data (w_head_bits),
        .full      (w_full),
        .empty     (w_empty)
    );

`ifdef ZB_SEQ_WATCHDOG_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_WD_W-1:0] r_wd_cnt;

    assign w_wd_expire = (r_state == RUN) && !postfilter_ready &&
                         (r_wd_cnt == c_WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd_cnt <= '0;
        end else if ((r_state != RUN) || postfilter_ready || w_wd_expire) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end
`else
    assign w_wd_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (enable) w_state_nxt = WARMUP;
            WARMUP: begin
                if (!enable)                               w_state_nxt = IDLE;
                else if (w_warm_done && postfilter_ready)  w_state_nxt = RUN;
            end
            RUN: begin
                if (!enable)          w_state_nxt = IDLE;
                else if (w_wd_expire) w_state_nxt = WARMUP;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period    <= '0;
            r_warm_cnt  <= '0;
            r_eoc       <= 1'b0;
            r_i_if      <= '0;
            r_q_if      <= '0;
            r_locked    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_locked <= (w_state_nxt == RUN);
            r_eoc    <= w_strobe;
            r_i_if   <= (w_strobe && !w_empty) ? w_head.i : '0;
            r_q_if   <= (w_strobe && !w_empty) ? w_head.q : '0;

            if (!w_active || w_strobe) r_period <= '0;
            else                       r_period <= r_period + 1'b1;

            // Strobes are never due in the evaluation cycle, so a restart cannot lose one.
            if ((r_state != WARMUP) || w_warm_done) r_warm_cnt <= '0;
            else if (w_strobe)                      r_warm_cnt <= r_warm_cnt + 1'b1;

            if (!w_active) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
                r_timeout   <= 1'b0;
            end else begin
                if (w_push && w_full && !w_strobe) r_overflow  <= 1'b1;
                if (w_strobe && w_empty)           r_underflow <= 1'b1;
                if (w_wd_expire)                   r_timeout   <= 1'b1;
            end
        end
    end

    assign eoc       = r_eoc;
    assign i_if      = r_i_if;
    assign q_if      = r_q_if;
    assign state     = r_state;
    assign locked    = r_locked;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign timeout   = r_timeout;

endmodule

`default_nettype wire

// File: doc/zb_decoder_sequencer.md
# zb_decoder_sequencer

Sequencer in front of `decoder_top`: buffers 4-bit I/Q ADC samples in a small FIFO and replays them to the decoder at a fixed cadence. Each replayed sample comes with a one-cycle `eoc` strobe. The block also runs a warm-up and lock state machine driven by `postfilter_ready`. It replaces the fixed-period stimulus logic and is the only driver of `eoc`, `I_IF` and `Q_IF`.

## Interface
- `EOC_PERIOD`, 5: cycles between `eoc` strobes; legal range 2..255.
- `FIFO_DEPTH`, 4: sample FIFO depth; must be a power of 2, 2..16.
- `WARMUP_SAMPLES`, 16: samples issued in WARMUP before `postfilter_ready` is evaluated; legal range 1..255.
- `TIMEOUT_CYCLES`, 256: watchdog limit; only used when `ZB_SEQ_WATCHDOG_EN` is defined.
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: run request; level-sensitive.
- `adc_valid` in 1: sample strobe.
- `adc_i` in 4: I sample.
- `adc_q` in 4: Q sample.
- `postfilter_ready` in 1: readiness indication from the decoder.
- `eoc` out 1: one-cycle strobe marking a valid `i_if`/`q_if`.
- `i_if` out 4: I sample to the decoder.
- `q_if` out 4: Q sample to the decoder.
- `state` out 2: FSM state, encoded IDLE=0, WARMUP=1, RUN=2.
- `locked` out 1: high while in RUN.
- `overflow` out 1: sticky; a sample was dropped because the FIFO was full.
- `underflow` out 1: sticky; a strobe was issued with the FIFO empty.
- `timeout` out 1: sticky watchdog flag; held at 0 when the watchdog is compiled out.

## Operation
- All outputs reset to 0, and the FSM resets to IDLE. The FIFO and all counters reset to empty/0.
- **IDLE**
  - Period counter held at 0.
  - FIFO is flushed.
  - No `eoc` is issued.
  - `adc_valid` is ignored.
  - The sticky flags clear on every cycle spent in IDLE.
  - Moves to WARMUP when `enable` = 1.
- **WARMUP and RUN**
  - Period counter counts 0..`EOC_PERIOD`-1 and wraps.
  - At terminal count (`EOC_PERIOD`-1) the block asserts `eoc` for one cycle.
  - If the FIFO is non-empty, it pops one entry onto `i_if`/`q_if`.
  - If the FIFO is empty, it drives `i_if`/`q_if` = 0 and sets `underflow`.
  - On every cycle without `eoc`, `i_if`/`q_if` = 0.
- **Push rules**
  - `adc_valid` outside IDLE pushes {`adc_i`, `adc_q`}.
  - If the FIFO is full and no pop occurs in that cycle, the sample is dropped and `overflow` is set.
  - A push and a pop in the same cycle on a full FIFO both succeed; `overflow` stays 0.
  - A push and a pop in the same cycle on an empty FIFO: the pop sees empty and zero-stuffs; the pushed sample is stored.
- **WARMUP**
  - Counts strobes issued since WARMUP entry, including zero-stuffed ones.
  - After strobe number `WARMUP_SAMPLES`, moves to RUN on the next cycle if `postfilter_ready` = 1.
  - Otherwise the strobe count restarts and WARMUP continues.
- **RUN**: `locked` = 1.
- **enable = 0**: from WARMUP or RUN the FSM moves to IDLE on the next edge. A strobe already due in that same cycle is still issued.

## Timing
- `eoc`, `i_if`, `q_if`, `state` and `locked` are all registered.
- After `enable` rises at edge t, `state` = WARMUP at t+1. The first `eoc` comes at t+1+`EOC_PERIOD`.
- `eoc` spacing is exactly `EOC_PERIOD` cycles in WARMUP and RUN. The period counter is not reset on WARMUP↔RUN transitions.
- A sample pushed at edge t can appear on a strobe no earlier than edge t+1. FIFO order is strict FIFO.
- `overflow`, `underflow` and `timeout` assert on the edge following the triggering condition.
- Asserting `reset` at any time forces reset values immediately (asynchronous). Recovery starts from IDLE.

## Configuration
- **`ZB_SEQ_WATCHDOG_EN` defined:**
  - In RUN, a cycle counter clears whenever `postfilter_ready` = 1 and increments otherwise.
  - When the counter reaches `TIMEOUT_CYCLES`, the block sets `timeout` and returns to WARMUP.
  - The FIFO and the period counter are kept across this return.
- **`ZB_SEQ_WATCHDOG_EN` undefined:** no watchdog logic is built, `timeout` is tied to 0, and RUN is left only through `enable` = 0 or `reset`.

## Structure
- **Package `zb_decoder_pkg`:**
  - `IQ_W` = 4.
  - `seq_state_t` enum {IDLE, WARMUP, RUN}.
  - `iq_sample_t` packed struct {i, q}.
- **Sub-module `zb_iq_fifo`:**
  - Synchronous FIFO, `FIFO_DEPTH` entries of `iq_sample_t`.
  - Ports: push, pop, flush, full, empty.
  - Defined same-cycle push/pop behaviour when full or empty, as in Operation.
- **Top:** FSM, period counter, warm-up counter, optional watchdog, sticky flags.

## Test plan
- `EOC_PERIOD`=5; enable; push samples 0x1/0xE … 0x4/0xB spaced 5 cycles apart -> `eoc` every 5 cycles carrying the samples in order; `i_if`/`q_if` = 0 between strobes.
- No `adc_valid` after enable -> `eoc` still every 5 cycles with data 0; `underflow` = 1; `overflow` = 0.
- Burst of 6 `adc_valid` in consecutive cycles into depth 4 -> first 4 (or 5 if a pop coincides) stored and replayed in order; `overflow` = 1.
- `WARMUP_SAMPLES`=16, `postfilter_ready` tied 1 -> `state`=RUN and `locked`=1 one cycle after the 16th `eoc`. With `postfilter_ready` tied 0 -> remains WARMUP.
- With `ZB_SEQ_WATCHDOG_EN`, `TIMEOUT_CYCLES`=256: lock, then hold `postfilter_ready`=0 -> after 256 cycles `timeout`=1, `state`=WARMUP, `eoc` cadence unbroken.
- `reset` mid-RUN, then `enable` dropped for 1 cycle -> all outputs 0 immediately after reset; IDLE clears flags and FIFO; re-enable gives first `eoc` at `EOC_PERIOD`+1 cycles.
